// File: rtl/clock_gate_pkg.sv
// Shared opcode and channel-mode encodings for the multi-channel clock gating controller.
package clock_gate_pkg;

    typedef enum logic [1:0] {
        CG_OP_STOP  = 2'd0,
        CG_OP_RUN   = 2'd1,
        CG_OP_BURST = 2'd2,
        CG_OP_NOP   = 2'd3
    } cg_op_t;

    typedef enum logic [1:0] {
        CG_MODE_OFF   = 2'd0,
        CG_MODE_RUN   = 2'd1,
        CG_MODE_BURST = 2'd2
    } cg_mode_t;

endpackage

// File: rtl/clock_gate_cell.sv
// Glitch-free clock gate: enable is captured while I is low, so O only ever carries full I high phases.
module clock_gate_cell (
    input  logic I,
    input  logic CE,
    output logic O
);

`ifdef CLOCK_GATE_USE_BUFGCE
    BUFGCE #(
        .CE_TYPE ("SYNC")
    ) u_bufgce (
        .I  (I),
        .CE (CE),
        .O  (O)
    );
`else
    logic ce_l;

    always_latch begin
        if (!I) begin
            ce_l <= CE;
        end
    end

    assign O = I & ce_l;
`endif

endmodule

// File: rtl/multi_clock_gate_ctrl.sv
// Command-driven controller producing CHANNELS gated clocks with stop / free-run / counted-burst modes.
//
//   state          | meaning
//   CG_MODE_OFF    | channel gated off, no pulses
//   CG_MODE_RUN    | channel pulses every cycle unless halted
//   CG_MODE_BURST  | channel pulses until rem reaches zero, then returns to OFF with a done pulse
module multi_clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CH_W-1:0]     cmd_chan,
    input  logic [1:0]          cmd_op,
    input  logic [COUNT_W-1:0]  cmd_count,
    input  logic                halt,
    output logic [CHANNELS-1:0] gclk,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] done
);

    cg_op_t op;
    logic   cmd_fire;

    assign cmd_ready = reset_n;
    assign op        = cg_op_t'(cmd_op);
    assign cmd_fire  = cmd_valid & cmd_ready & (op != CG_OP_NOP);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        cg_mode_t           mode_q, mode_d;
        logic [COUNT_W-1:0] rem_q, rem_d;
        logic               g_q, g_d;
        logic               done_q, done_d;
        logic               hit;

        // Out-of-range channel indices never match any channel, so they fall through silently.
        assign hit = cmd_fire & (cmd_chan == CH_W'(i));

        always_comb begin
            mode_d = mode_q;
            rem_d  = rem_q;
            done_d = 1'b0;
            if (hit) begin
                case (op)
                    CG_OP_STOP: mode_d = CG_MODE_OFF;
                    CG_OP_RUN:  mode_d = CG_MODE_RUN;
                    CG_OP_BURST: begin
                        if (cmd_count == '0) begin
                            mode_d = CG_MODE_OFF;
                            done_d = 1'b1;
                        end else begin
                            mode_d = CG_MODE_BURST;
                            rem_d  = cmd_count;
                        end
                    end
                    default: mode_d = mode_q;
                endcase
            end else if (g_q && (mode_q == CG_MODE_BURST)) begin
                // g_q high at this edge means the gate passed a pulse on it.
                rem_d = rem_q - COUNT_W'(1);
                if (rem_q == COUNT_W'(1)) begin
                    mode_d = CG_MODE_OFF;
                    done_d = 1'b1;
                end
            end
            g_d = (mode_d != CG_MODE_OFF) & ~halt;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                mode_q <= CG_MODE_OFF;
                rem_q  <= '0;
                g_q    <= 1'b0;
                done_q <= 1'b0;
            end else begin
                mode_q <= mode_d;
                rem_q  <= rem_d;
                g_q    <= g_d;
                done_q <= done_d;
            end
        end

        clock_gate_cell u_cell (
            .I  (clock),
            .CE (g_q),
            .O  (gclk[i])
        );

        assign running[i] = g_q;
        assign done[i]    = done_q;
    end

endmodule
